capture_reader: RTL
===================

Name: capture_reader

Overview:
- Read side of the capture memory: walks a stored sample buffer and streams each word out over a valid/ready interface.
- Software or the monitor controller supplies a start address and word count. The block issues reads to a synchronous RAM port with 1-cycle latency and wraps around the circular buffer.
- It buffers read data so the stream sustains 1 word/cycle, and it holds the data steady under backpressure.

Parameters:
- DATA_W, 8, width of one memory word and of out_data.
- ADDR_W, 10, memory address width. DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; starts a readout. Sampled only in IDLE.
- start_addr  in  ADDR_W  first address to read.
- length  in  ADDR_W+1  number of words to read, 0..DEPTH.
- abort  in  1  synchronous cancel of the readout in progress.
- busy  out  1  high from the start edge until return to IDLE.
- done  out  1  one-cycle pulse after the final word handshake.
- mem_re  out  1  read enable to the RAM.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  RAM data, valid the cycle after mem_re.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_last  out  1  high with the final word of the readout.

Behaviour:
- Reset: state IDLE, buffer empty, counters cleared. Outputs busy, done, mem_re, out_valid, out_last = 0; mem_addr = 0; out_data = 0.
- States:
  - IDLE: start=1 with length>0 goes to READ. Load addr=start_addr, issue_cnt=length, xfer_cnt=length. busy goes 1 at that edge.
  - IDLE with start=1 and length=0: go to FIN; no memory reads are issued.
  - READ: reads are being issued and/or the buffer is draining.
  - FIN: done=1 for exactly one cycle, then IDLE. busy is 0 in FIN.
- Read issue:
  - mem_re = (state==READ) && issue_cnt!=0 && (occupancy + inflight) < 2.
  - The buffer is a 2-entry FIFO. inflight is 1 if mem_re was high in the previous cycle.
  - mem_addr = addr. On each mem_re, addr increments modulo DEPTH (DEPTH-1 wraps to 0) and issue_cnt decrements.
- Data capture: the cycle after mem_re, mem_rdata is written into the FIFO.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A word transfers when out_valid && out_ready. On each transfer xfer_cnt decrements.
  - out_last = out_valid && xfer_cnt==1.
- Timing: with start sampled at edge T:
  - mem_re is first high in cycle T+1.
  - out_valid is first high in cycle T+2.
  - With out_ready held at 1, one word transfers every cycle with no bubbles.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and out_last hold stable. At most 2 words are ever buffered or in flight, so no RAM data is lost.
- Completion: at the transfer edge where xfer_cnt==1, go to FIN. done pulses in the next cycle.
- start while busy is ignored: no effect on counters and no second done.
- abort:
  - In READ, at the next edge: go to IDLE, flush the FIFO, discard any in-flight data, clear counters. No done pulse.
  - abort in IDLE or FIN has no effect (the FIN done pulse still occurs).
  - abort and start in the same IDLE cycle: start wins.
- Reset mid-operation: same as the reset values above. An in-flight RAM word is discarded.
- length == DEPTH: every location is read exactly once, ending at start_addr-1 mod DEPTH.

Decomposition:
- Shared package (capture_pkg):
  - state encoding constants ST_IDLE, ST_READ, ST_FIN;
  - default DATA_W/ADDR_W;
  - the RAM read-latency constant RD_LAT=1, which the memory writer block shares.
- One sub-module: rd_skid_fifo, a 2-entry synchronous FIFO.
  - Ports: clk, reset, flush, wr_en, wr_data, rd_en, rd_data, empty, count.
  - capture_reader keeps the FSM, counters and issue logic.

Test Plan:
- Basic: memory preloaded with mem[i]=i. start_addr=5, length=4, out_ready=1.
  - mem_re is high in cycles T+1..T+4 with addresses 5,6,7,8.
  - out_data is 5,6,7,8 in cycles T+2..T+5; out_last is high only with 8.
  - done pulses in T+6; busy drops the same cycle.
- Wrap: ADDR_W=4, start_addr=14, length=4 → addresses 14,15,0,1; data in that order.
- Backpressure: length=6 with out_ready toggling 1,0,0,1,0,1,...
  - All 6 words are delivered in order, with no duplicates or drops.
  - out_data is stable during stalls; mem_re is never high when occupancy+inflight=2.
- Zero length: start with length=0 → no mem_re, no out_valid, done pulse one cycle later.
- Full depth: ADDR_W=4, length=16, start_addr=3 → 16 words in order 3..15,0..2; exactly one out_last.
- Abort and reset:
  - abort after 2 transfers of a length=8 readout → IDLE next cycle, out_valid=0, no done.
  - A new start afterwards reads correctly.
  - Repeat with reset instead of abort; all outputs show their reset values.

Source files
------------

// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared constants and types for the capture memory blocks
// Purpose: state encoding for the capture reader, default widths, and the
//          RAM read latency shared with the capture memory writer.
// Ports:   none (package).
package capture_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  // Synchronous RAM port: data appears this many cycles after the read enable.
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// rtl/rd_skid_fifo.sv - 2-entry fall-through FIFO for RAM read data
// Purpose: holds up to two RAM words in front of the output stream. A word
//          arriving on wr_en while the FIFO is empty is presented on rd_data
//          in the same cycle, so RAM data reaches the stream without an extra
//          register stage.
// Ports:   clk, reset  - clock, synchronous active-high reset
//          flush       - synchronous clear of all stored words
//          wr_en/wr_data - incoming RAM word
//          rd_en       - consume the head word (only while !empty)
//          rd_data     - head word (stored head, else the arriving word, else 0)
//          empty       - no stored word and nothing arriving
//          count       - number of stored words (0..2)
module rd_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wptr_q;
  logic              rptr_q;
  logic [1:0]        count_q;
  logic              bypass;
  logic              push;
  logic              pop;

  // Arriving word consumed in the same cycle never touches storage.
  assign bypass = (count_q == 2'd0) && wr_en && rd_en;
  assign push   = wr_en && !bypass;
  assign pop    = rd_en && (count_q != 2'd0);

  assign empty   = (count_q == 2'd0) && !wr_en;
  assign count   = count_q;
  assign rd_data = (count_q != 2'd0) ? mem_q[rptr_q] :
                   (wr_en ? wr_data : '0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/capture_reader.sv
// rtl/capture_reader.sv - streams a region of the circular capture buffer
// Purpose: on start, reads length words from the capture RAM beginning at
//          start_addr (wrapping modulo DEPTH) and streams them out over a
//          valid/ready interface at up to one word per cycle.
// Ports:   clk, reset              - clock, synchronous active-high reset
//          start/start_addr/length - launch a readout (sampled in IDLE)
//          abort                   - cancel the readout in progress
//          busy, done              - readout active / one-cycle completion pulse
//          mem_re/mem_addr/mem_rdata - RAM read port, data one cycle after mem_re
//          out_data/out_valid/out_ready/out_last - output stream
module capture_reader
  import capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  xfer_cnt_q;
  logic              inflight_q;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic [1:0]        pending;
  logic              fire;
  logic              kill;

  // Words buffered plus the one on its way from the RAM; capped at two so the
  // FIFO can always absorb returning data even under full backpressure.
  assign pending = fifo_count + {1'b0, inflight_q};
  assign mem_re  = (state_q == ST_READ) && (issue_cnt_q != '0) && (pending < 2'd2);
  assign mem_addr = addr_q;

  assign out_valid = !fifo_empty;
  assign fire      = out_valid && out_ready;
  assign out_last  = out_valid && (xfer_cnt_q == CNT_W'(1));
  assign kill      = (state_q == ST_READ) && abort;

  assign busy = (state_q == ST_READ);
  assign done = (state_q == ST_FIN);

  rd_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (kill),
    .wr_en   (inflight_q),
    .wr_data (mem_rdata),
    .rd_en   (fire),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (length != '0) ? ST_READ : ST_FIN;
      end
      ST_READ: begin
        // Abort takes priority over completion of the final word.
        if (abort)                                    state_d = ST_IDLE;
        else if (fire && (xfer_cnt_q == CNT_W'(1)))   state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= mem_re;
      if ((state_q == ST_IDLE) && start) begin
        addr_q      <= start_addr;
        issue_cnt_q <= length;
        xfer_cnt_q  <= length;
      end else begin
        if (mem_re) begin
          addr_q      <= addr_q + ADDR_W'(1);
          issue_cnt_q <= issue_cnt_q - CNT_W'(1);
        end
        if (fire) xfer_cnt_q <= xfer_cnt_q - CNT_W'(1);
      end
    end
  end

endmodule
